// File: rtl/ddr_lane_dly_seq.sv
`default_nettype none
// ============================================================================
// Module   : ddr_lane_dly_seq
// Purpose  : Delay-line sequencer for NUM_LANES DDR PHY byte lanes. Accepts
//            tap-adjust commands over a valid/ready handshake, brackets each
//            adjustment with an HS_IO_CLK_PAUSE window, issues LOAD/MOVE/
//            DIRECTION pulses to the selected lane controller, tracks a
//            per-lane tap count and aborts on delay-line out-of-range.
// Ports    : FAB_CLK/RESET        - fabric clock, synchronous active-high reset
//            CMD_VALID/CMD_READY  - command handshake (READY only in IDLE)
//            CMD_LANE/OP/STEPS    - target lane, opcode, INC/DEC step count
//            DONE/DONE_ERR        - completion pulse and its error flag
//            BUSY                 - high outside IDLE
//            DELAY_LINE_*         - per-lane LOAD/MOVE/DIRECTION pulses
//            HS_IO_CLK_PAUSE      - per-lane pause request
//            DELAY_LINE_OUT_OF_RANGE - per-lane range flag from lane controller
//            TAP_COUNT            - packed per-lane tap counts
// Options  : DDR_LANE_DLY_SEQ_BROADCAST_EN - CMD_LANE all-ones drives all lanes
// Revision : 1.0 - initial release
// ============================================================================
module ddr_lane_dly_seq #(
    parameter int NUM_LANES  = 4,
    parameter int TAP_W      = 8,
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2,
    parameter int LANE_W     = $clog2(NUM_LANES) + 1
) (
    input  logic                       FAB_CLK,
    input  logic                       RESET,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [LANE_W-1:0]          CMD_LANE,
    input  logic [1:0]                 CMD_OP,
    input  logic [TAP_W-1:0]           CMD_STEPS,
    output logic                       DONE,
    output logic                       DONE_ERR,
    output logic                       BUSY,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       HS_IO_CLK_PAUSE,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0] TAP_COUNT
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_POST  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Wait-counter reload values: the counter counts down to zero, so the
    // state is held (value + 1) cycles.
    localparam logic [3:0] PRE_LD  = 4'((PAUSE_PRE  > 0) ? PAUSE_PRE  - 1 : 0);
    localparam logic [3:0] POST_LD = 4'((PAUSE_POST > 0) ? PAUSE_POST - 1 : 0);

    // A zero-length post window skips POST entirely so pause drops on FIN.
    localparam logic [2:0] S_AFTER = (PAUSE_POST == 0) ? S_FIN : S_POST;

    localparam logic [TAP_W:0] TAP_MAX = {1'b0, {TAP_W{1'b1}}};

    logic [2:0]           state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [1:0]           op_q, op_d;
    logic [TAP_W-1:0]     steps_q, steps_d;
    logic [3:0]           wait_q, wait_d;
    logic                 err_q, err_d;
    logic                 ready_q;
    logic [NUM_LANES-1:0] dir_q, dir_d;
    logic [TAP_W-1:0]     tap_q [NUM_LANES];
    logic [TAP_W-1:0]     tap_d [NUM_LANES];

    logic                 w_bcast;
    logic [NUM_LANES-1:0] w_mask;
    logic                 w_range_bad;
    logic                 w_reject;
    logic                 w_oor;
    logic                 w_active;

`ifdef DDR_LANE_DLY_SEQ_BROADCAST_EN
    assign w_bcast = &lane_q;
`else
    assign w_bcast = 1'b0;
`endif

    // Lanes touched by the captured command; empty for an invalid lane.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_mask[i] = w_bcast || (lane_q == LANE_W'(i));
        end
    end

    // Range check against every selected lane (worst case for broadcast).
    always_comb begin
        w_range_bad = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_mask[i]) begin
                if ((op_q == OP_INC) && (({1'b0, tap_q[i]} + {1'b0, steps_q}) > TAP_MAX)) begin
                    w_range_bad = 1'b1;
                end
                if ((op_q == OP_DEC) && (steps_q > tap_q[i])) begin
                    w_range_bad = 1'b1;
                end
            end
        end
    end

    assign w_reject = (w_mask == '0) || (op_q == OP_RSVD) || w_range_bad;
    assign w_oor    = |(DELAY_LINE_OUT_OF_RANGE & w_mask);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        op_d    = op_q;
        steps_d = steps_q;
        wait_d  = wait_q;
        err_d   = err_q;
        dir_d   = dir_q;
        tap_d   = tap_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && ready_q) begin
                    lane_d  = CMD_LANE;
                    op_d    = CMD_OP;
                    steps_d = CMD_STEPS;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_reject) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if ((op_q != OP_LOAD) && (steps_q == '0)) begin
                    state_d = S_FIN;
                end else begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (w_mask[i]) begin
                            dir_d[i] = (op_q != OP_DEC);
                        end
                    end
                    wait_d  = PRE_LD;
                    state_d = (PAUSE_PRE == 0) ? S_ACT : S_PRE;
                end
            end
            S_PRE: begin
                if (wait_q == 4'd0) begin
                    state_d = S_ACT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_ACT: begin
                // The pulse in this cycle is issued regardless of the range
                // flag, so the count always follows it.
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (w_mask[i]) begin
                        if (op_q == OP_LOAD) begin
                            tap_d[i] = '0;
                        end else if (op_q == OP_INC) begin
                            tap_d[i] = tap_q[i] + TAP_W'(1);
                        end else begin
                            tap_d[i] = tap_q[i] - TAP_W'(1);
                        end
                    end
                end
                if (op_q != OP_LOAD) begin
                    steps_d = steps_q - TAP_W'(1);
                end
                if (w_oor) begin
                    err_d = 1'b1;
                end
                if ((op_q == OP_LOAD) || w_oor) begin
                    wait_d  = POST_LD;
                    state_d = S_AFTER;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (w_oor) begin
                    err_d   = 1'b1;
                    wait_d  = POST_LD;
                    state_d = S_AFTER;
                end else if (steps_q == '0) begin
                    wait_d  = POST_LD;
                    state_d = S_AFTER;
                end else begin
                    state_d = S_ACT;
                end
            end
            S_POST: begin
                if (wait_q == 4'd0) begin
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            op_q    <= '0;
            steps_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            dir_q   <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            steps_q <= steps_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            // Registered so READY stays low during reset and rises one
            // cycle after release.
            ready_q <= (state_d == S_IDLE);
            dir_q   <= dir_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

    assign w_active = (state_q == S_PRE) || (state_q == S_ACT) ||
                      (state_q == S_GAP) || (state_q == S_POST);

    assign CMD_READY            = ready_q;
    assign BUSY                 = (state_q != S_IDLE);
    assign DONE                 = (state_q == S_FIN);
    assign DONE_ERR             = (state_q == S_FIN) && err_q;
    assign HS_IO_CLK_PAUSE      = w_active ? w_mask : '0;
    assign DELAY_LINE_LOAD      = ((state_q == S_ACT) && (op_q == OP_LOAD)) ? w_mask : '0;
    assign DELAY_LINE_MOVE      = ((state_q == S_ACT) && (op_q != OP_LOAD)) ? w_mask : '0;
    assign DELAY_LINE_DIRECTION = dir_q;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
            assign TAP_COUNT[g*TAP_W +: TAP_W] = tap_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ddr_lane_dly_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_lane_dly_seq
// Purpose  : Self-checking bench for ddr_lane_dly_seq (default parameters).
//            A command-level model predicts the per-cycle output trace and
//            the resulting tap counts; directed and random commands follow.
// Options  : DDR_LANE_DLY_SEQ_BROADCAST_EN - enables broadcast expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_lane_dly_seq;

    localparam int NL = 4;
    localparam int TW = 8;

`ifdef DDR_LANE_DLY_SEQ_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] pause;
        logic [3:0] load;
        logic [3:0] move;
        logic       done;
        logic       err;
    } exp_t;

    logic           FAB_CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           CMD_VALID = 1'b0;
    logic           CMD_READY;
    logic [2:0]     CMD_LANE = '0;
    logic [1:0]     CMD_OP = '0;
    logic [TW-1:0]  CMD_STEPS = '0;
    logic           DONE;
    logic           DONE_ERR;
    logic           BUSY;
    logic [NL-1:0]  DELAY_LINE_LOAD;
    logic [NL-1:0]  DELAY_LINE_MOVE;
    logic [NL-1:0]  DELAY_LINE_DIRECTION;
    logic [NL-1:0]  HS_IO_CLK_PAUSE;
    logic [NL-1:0]  DELAY_LINE_OUT_OF_RANGE = '0;
    logic [NL*TW-1:0] TAP_COUNT;

    int             vectors;
    int             miscompares;
    int             model_tap [NL];
    logic [NL-1:0]  model_dir;

    ddr_lane_dly_seq dut (
        .FAB_CLK                 (FAB_CLK),
        .RESET                   (RESET),
        .CMD_VALID               (CMD_VALID),
        .CMD_READY               (CMD_READY),
        .CMD_LANE                (CMD_LANE),
        .CMD_OP                  (CMD_OP),
        .CMD_STEPS               (CMD_STEPS),
        .DONE                    (DONE),
        .DONE_ERR                (DONE_ERR),
        .BUSY                    (BUSY),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .HS_IO_CLK_PAUSE         (HS_IO_CLK_PAUSE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .TAP_COUNT               (TAP_COUNT)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    function automatic logic [19:0] pack_obs();
        return {HS_IO_CLK_PAUSE, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                DONE, DONE_ERR, BUSY, CMD_READY, DELAY_LINE_DIRECTION};
    endfunction

    function automatic logic [31:0] model_taps();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*TW +: TW] = 8'(model_tap[i]);
        return r;
    endfunction

    function automatic exp_t mk(input logic [3:0] p, input logic [3:0] l,
                                input logic [3:0] m, input logic d, input logic e);
        exp_t x;
        x.pause = p;
        x.load  = l;
        x.move  = m;
        x.done  = d;
        x.err   = e;
        return x;
    endfunction

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle"}, 0, 32'(pack_obs()), 32'({12'h0, 1'b0, 1'b0, 1'b0, 1'b1, model_dir}));
        check({tag, "_taps"}, 0, TAP_COUNT, model_taps());
    endtask

    // Issues one command (called right after a falling edge) and checks the
    // whole response trace cycle by cycle. oor_after>0 raises the range flag
    // in the gap following that many moves; rst_at>=0 asserts reset after
    // that trace cycle.
    task automatic run_cmd(input string tag, input logic [2:0] lane, input logic [1:0] op,
                           input logic [7:0] steps, input int oor_after, input bit hold,
                           input int rst_at);
        logic [3:0]  mask;
        logic [3:0]  old_dir;
        logic [3:0]  new_dir;
        logic [19:0] e;
        bit          reject;
        bit          nul;
        bit          abort;
        bit          stopped;
        int          nmoves;
        int          oor_cyc;
        exp_t        q[$];

        mask = '0;
        for (int i = 0; i < NL; i++) begin
            if ((BCAST && lane == 3'd7) || lane == 3'(i)) mask[i] = 1'b1;
        end
        reject = (mask == 4'h0) || (op == 2'd3);
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                if (op == 2'd1 && model_tap[i] + int'(steps) > 255) reject = 1'b1;
                if (op == 2'd2 && int'(steps) > model_tap[i]) reject = 1'b1;
            end
        end
        nul     = !reject && (op != 2'd0) && (steps == 8'd0);
        abort   = !reject && !nul && (op != 2'd0) && (oor_after > 0);
        nmoves  = abort ? oor_after : int'(steps);
        old_dir = model_dir;
        new_dir = model_dir;
        if (!reject && !nul) begin
            for (int i = 0; i < NL; i++) if (mask[i]) new_dir[i] = (op != 2'd2);
        end

        oor_cyc = -1;
        q.push_back(mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        if (reject || nul) begin
            q.push_back(mk(4'h0, 4'h0, 4'h0, 1'b1, reject));
        end else begin
            repeat (2) q.push_back(mk(mask, 4'h0, 4'h0, 1'b0, 1'b0));
            if (op == 2'd0) begin
                q.push_back(mk(mask, mask, 4'h0, 1'b0, 1'b0));
            end else begin
                for (int m = 0; m < nmoves; m++) begin
                    q.push_back(mk(mask, 4'h0, mask, 1'b0, 1'b0));
                    q.push_back(mk(mask, 4'h0, 4'h0, 1'b0, 1'b0));
                end
            end
            if (abort) oor_cyc = q.size() - 1;
            repeat (2) q.push_back(mk(mask, 4'h0, 4'h0, 1'b0, 1'b0));
            q.push_back(mk(4'h0, 4'h0, 4'h0, 1'b1, abort));
        end

        CMD_LANE  = lane;
        CMD_OP    = op;
        CMD_STEPS = steps;
        CMD_VALID = 1'b1;
        @(posedge FAB_CLK);
        stopped = 1'b0;
        for (int k = 0; k < q.size() && !stopped; k++) begin
            @(negedge FAB_CLK);
            e = {q[k].pause, q[k].load, q[k].move, q[k].done, q[k].err, 1'b1, 1'b0,
                 (k == 0) ? old_dir : new_dir};
            check(tag, k + 1, 32'(pack_obs()), 32'(e));
            if (k == 0) begin
                if (hold) begin
                    CMD_LANE  = 3'($urandom_range(0, 3));
                    CMD_OP    = 2'($urandom_range(0, 2));
                    CMD_STEPS = 8'($urandom_range(1, 9));
                end else begin
                    CMD_VALID = 1'b0;
                end
            end
            if (k == q.size() - 1) CMD_VALID = 1'b0;
            DELAY_LINE_OUT_OF_RANGE = 4'($urandom) & ~mask;
            if (oor_cyc >= 0 && k >= oor_cyc) DELAY_LINE_OUT_OF_RANGE = DELAY_LINE_OUT_OF_RANGE | mask;
            if (k == rst_at) begin
                RESET     = 1'b1;
                CMD_VALID = 1'b0;
                stopped   = 1'b1;
            end
        end
        DELAY_LINE_OUT_OF_RANGE = '0;

        if (stopped) begin
            @(negedge FAB_CLK);
            check({tag, "_rst_outs"}, 0, 32'(pack_obs()), 32'h0);
            check({tag, "_rst_taps"}, 0, TAP_COUNT, 32'h0);
            RESET = 1'b0;
            for (int i = 0; i < NL; i++) model_tap[i] = 0;
            model_dir = '0;
            @(negedge FAB_CLK);
            check_idle({tag, "_rel"});
        end else begin
            if (!reject && !nul) begin
                for (int i = 0; i < NL; i++) begin
                    if (mask[i]) begin
                        if (op == 2'd0) model_tap[i] = 0;
                        else if (op == 2'd1) model_tap[i] = model_tap[i] + nmoves;
                        else model_tap[i] = model_tap[i] - nmoves;
                    end
                end
            end
            model_dir = new_dir;
            @(negedge FAB_CLK);
            check_idle(tag);
        end
    endtask

    initial begin
        logic [2:0] r_lane;
        logic [1:0] r_op;
        logic [7:0] r_steps;
        int         r_oor;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < NL; i++) model_tap[i] = 0;
        model_dir = '0;

        RESET = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        check("reset_outs", 0, 32'(pack_obs()), 32'h0);
        check("reset_taps", 0, TAP_COUNT, 32'h0);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        check_idle("post_reset");

        run_cmd("load_l2",      3'd2, 2'd0, 8'd0,   0, 1'b0, -1);
        run_cmd("inc_l1_3",     3'd1, 2'd1, 8'd3,   0, 1'b0, -1);
        run_cmd("inc_l0_250",   3'd0, 2'd1, 8'd250, 0, 1'b0, -1);
        run_cmd("inc_ovf",      3'd0, 2'd1, 8'd10,  0, 1'b0, -1);
        run_cmd("dec_unf",      3'd0, 2'd2, 8'd251, 0, 1'b0, -1);
        run_cmd("inc_to_max",   3'd0, 2'd1, 8'd5,   0, 1'b0, -1);
        run_cmd("dec_to_zero",  3'd0, 2'd2, 8'd255, 0, 1'b0, -1);
        run_cmd("dec_at_zero",  3'd0, 2'd2, 8'd1,   0, 1'b0, -1);
        run_cmd("inc_l3_oor",   3'd3, 2'd1, 8'd8,   4, 1'b0, -1);
        run_cmd("bad_lane",     3'd4, 2'd1, 8'd1,   0, 1'b0, -1);
        run_cmd("rsvd_op",      3'd1, 2'd3, 8'd1,   0, 1'b0, -1);
        run_cmd("zero_steps",   3'd1, 2'd1, 8'd0,   0, 1'b0, -1);
        run_cmd("all_ones_inc", 3'd7, 2'd1, 8'd2,   0, 1'b1, -1);
        run_cmd("dec_l1_hold",  3'd1, 2'd2, 8'd2,   0, 1'b1, -1);
        run_cmd("rst_in_gap",   3'd0, 2'd1, 8'd5,   0, 1'b1,  6);

        for (int n = 0; n < 40; n++) begin
            r_lane  = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
            r_op    = 2'($urandom_range(0, 3));
            r_steps = 8'($urandom_range(0, 12));
            r_oor   = 0;
            if (r_steps != 8'd0 && $urandom_range(0, 3) == 0) r_oor = $urandom_range(1, int'(r_steps));
            run_cmd("rand", r_lane, r_op, r_steps, r_oor, n[0], -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
